// File: rtl/sync_fifo_pkg.sv
// Shared types and sizing helpers for the single-clock FIFO.
package sync_fifo_pkg;

  localparam int ASIZE_DEF = 8;
  localparam int DEPTH = 1 << ASIZE_DEF;

  typedef logic [ASIZE_DEF:0] level_t;

  function automatic int lvl_w(input int asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Register-array storage: one write port, one read port.
// FALLTHROUGH="TRUE" gives a combinational read, else a registered one.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int ASIZE = 8,
  parameter FALLTHROUGH = "FALSE"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int NWORDS = 1 << ASIZE;

  logic [DSIZE-1:0] mem [NWORDS];
  logic [DSIZE-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= '0;
    else if (re) rd_q <= mem[raddr];
  end

  // Fall-through mode leaves rd_q dangling; synthesis prunes it.
  assign rdata = (FALLTHROUGH == "TRUE") ? mem[raddr] : rd_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact level and programmable almost flags.
// Define SYNC_FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int ASIZE = 8,
  parameter FALLTHROUGH = "FALSE"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  input  logic [ASIZE:0]   afull_thr,
  input  logic [ASIZE:0]   aempty_thr,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr,
`endif
  output logic [ASIZE:0]   level
);

  localparam int LW = lvl_w(ASIZE);
  localparam int NWORDS = 1 << ASIZE;

  logic [ASIZE-1:0] wptr, rptr;
  logic [LW-1:0]    lvl_q, lvl_nx;
  logic             wr_acc, rd_acc;

  // Gating uses the registered flags, so full+both is read-only
  // and empty+both is write-only.
  assign wr_acc = winc & ~wfull;
  assign rd_acc = rinc & ~rempty;
  assign lvl_nx = lvl_q + LW'(wr_acc) - LW'(rd_acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      lvl_q   <= '0;
      wfull   <= 1'b0;
      awfull  <= 1'b0;
      rempty  <= 1'b1;
      arempty <= 1'b1;
    end else begin
      wptr    <= wptr + ASIZE'(wr_acc);
      rptr    <= rptr + ASIZE'(rd_acc);
      lvl_q   <= lvl_nx;
      wfull   <= lvl_nx == LW'(NWORDS);
      awfull  <= lvl_nx >= afull_thr;
      rempty  <= lvl_nx == '0;
      arempty <= lvl_nx <= aempty_thr;
    end
  end

  assign level = lvl_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc & wfull) overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (rinc & rempty) underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end
`endif

  sync_fifo_ram #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE),
    .FALLTHROUGH(FALLTHROUGH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_acc & rst_n),
    .waddr(wptr),
    .wdata(wdata),
    .re   (rd_acc & rst_n),
    .raddr(rptr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: standard and fall-through instances.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        winc = 1'b0, rinc = 1'b0;
  logic [15:0] wdata = '0, rdata;
  logic        wfull, awfull, rempty, arempty;
  logic [8:0]  afull_thr = 9'd200, aempty_thr = 9'd4;
  logic [8:0]  level;
  logic        err_clr = 1'b0;

  logic        f_winc = 1'b0, f_rinc = 1'b0;
  logic [15:0] f_wdata = '0, f_rdata;
  logic        f_wfull, f_awfull, f_rempty, f_arempty;
  logic [8:0]  f_level;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic        overflow, underflow, f_ovf, f_unf;
`endif

  always #5 clk = ~clk;

  sync_fifo #(.DSIZE(16), .ASIZE(8), .FALLTHROUGH("FALSE")) dut (
    .clk(clk), .rst_n(rst_n),
    .winc(winc), .wdata(wdata), .wfull(wfull), .awfull(awfull),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .arempty(arempty),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr),
`endif
    .level(level)
  );

  sync_fifo #(.DSIZE(16), .ASIZE(8), .FALLTHROUGH("TRUE")) dut_f (
    .clk(clk), .rst_n(rst_n),
    .winc(f_winc), .wdata(f_wdata), .wfull(f_wfull), .awfull(f_awfull),
    .rinc(f_rinc), .rdata(f_rdata), .rempty(f_rempty), .arempty(f_arempty),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr),
`endif
    .level(f_level)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] q[$];
  int          cnt = 0;
  logic [15:0] last = '0;
  logic        ovf_m = 1'b0, unf_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [15:0] d);
    logic wa, ra;
    wa = w && cnt != DEPTH;
    ra = r && cnt != 0;
    ovf_m = (w && cnt == DEPTH) ? 1'b1 : (err_clr ? 1'b0 : ovf_m);
    unf_m = (r && cnt == 0) ? 1'b1 : (err_clr ? 1'b0 : unf_m);
    winc = w; rinc = r; wdata = d;
    @(posedge clk); #1;
    winc = 1'b0; rinc = 1'b0;
    if (wa) q.push_back(d);
    if (ra) last = q.pop_front();
    cnt = cnt + int'(wa) - int'(ra);
    chk("level", 32'(level), 32'(cnt));
    chk("wfull", 32'(wfull), 32'(cnt == DEPTH));
    chk("rempty", 32'(rempty), 32'(cnt == 0));
    chk("awfull", 32'(awfull), 32'(cnt >= int'(afull_thr)));
    chk("arempty", 32'(arempty), 32'(cnt <= int'(aempty_thr)));
    chk("rdata", 32'(rdata), 32'(last));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("underflow", 32'(underflow), 32'(unf_m));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; winc = 1'b1; rinc = 1'b1; wdata = 16'hDEAD;
    @(posedge clk); #1;
    rst_n = 1'b1; winc = 1'b0; rinc = 1'b0;
    q.delete(); cnt = 0; last = '0; ovf_m = 1'b0; unf_m = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_arempty", 32'(arempty), 32'd1);
    chk("rst_wfull", 32'(wfull), 32'd0);
    chk("rst_awfull", 32'(awfull), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
`endif
  endtask

  initial begin
    do_reset();

    // fill to full; awfull rises at 200, wfull at 256
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 16'(i * 7 + 3));
    chk("full_level", 32'(level), 32'd256);
    chk("full_flag", 32'(wfull), 32'd1);

    // 257th write is dropped
    cyc(1'b1, 1'b0, 16'hBEEF);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_set", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 16'h0);
    chk("ovf_hold", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 16'h0);
    err_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
`endif

    // full with both requests: read only
    cyc(1'b1, 1'b1, 16'hCAFE);
    chk("full_both_level", 32'(level), 32'd255);
    chk("full_both_rdata", 32'(rdata), 32'h3);
    cyc(1'b1, 1'b0, 16'h7777);

    // drain everything in order
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 16'h0);
    chk("drain_rempty", 32'(rempty), 32'd1);
    chk("drain_last", 32'(rdata), 32'h7777);

    // read while empty: rdata holds
    cyc(1'b0, 1'b1, 16'h0);
    chk("empty_rd_hold", 32'(rdata), 32'h7777);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clr = 1'b1;
    cyc(1'b0, 1'b1, 16'h0);
    err_clr = 1'b0;
    chk("unf_set_wins", 32'(underflow), 32'd1);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 16'h0);
    err_clr = 1'b0;
    chk("unf_clr", 32'(underflow), 32'd0);
`endif

    // empty with both requests: write only
    cyc(1'b1, 1'b1, 16'h4242);
    chk("empty_both_level", 32'(level), 32'd1);
    chk("empty_both_rempty", 32'(rempty), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("empty_both_unf", 32'(underflow), 32'd0);
`endif

    // bring level to 128, then stream across pointer wrap
    for (int i = 0; i < 127; i++) cyc(1'b1, 1'b0, 16'(16'h1000 + i));
    chk("lvl128", 32'(level), 32'd128);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 16'(16'h8000 + i));
    chk("stream_level", 32'(level), 32'd128);

    // threshold changes take effect on the next edge
    afull_thr = 9'd100;
    cyc(1'b0, 1'b0, 16'h0);
    chk("thr_afull_on", 32'(awfull), 32'd1);
    afull_thr = 9'd300;
    cyc(1'b0, 1'b0, 16'h0);
    chk("thr_afull_off", 32'(awfull), 32'd0);
    aempty_thr = 9'd0;

    // drain to 77, then reset mid-operation
    for (int i = 0; i < 51; i++) cyc(1'b0, 1'b1, 16'h0);
    chk("lvl77", 32'(level), 32'd77);
    do_reset();
    cyc(1'b1, 1'b0, 16'h5A5A);
    chk("post_rst_arempty", 32'(arempty), 32'd0);
    cyc(1'b0, 1'b1, 16'h0);
    chk("post_rst_data", 32'(rdata), 32'h5A5A);
    chk("post_rst_arempty0", 32'(arempty), 32'd1);

    // fall-through instance
    f_wdata = 16'hA5A5; f_winc = 1'b1;
    @(posedge clk); #1;
    f_winc = 1'b0;
    chk("fwft_rempty", 32'(f_rempty), 32'd0);
    chk("fwft_rdata", 32'(f_rdata), 32'hA5A5);
    chk("fwft_level", 32'(f_level), 32'd1);
    f_wdata = 16'h1234; f_winc = 1'b1;
    @(posedge clk); #1;
    f_winc = 1'b0;
    chk("fwft_head_hold", 32'(f_rdata), 32'hA5A5);
    f_rinc = 1'b1;
    @(posedge clk); #1;
    f_rinc = 1'b0;
    chk("fwft_next", 32'(f_rdata), 32'h1234);
    chk("fwft_level1", 32'(f_level), 32'd1);
    f_rinc = 1'b1;
    @(posedge clk); #1;
    f_rinc = 1'b0;
    chk("fwft_empty", 32'(f_rempty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
